// File: rtl/add_int32_pkg.sv
// Shared constants and FSM state type for the int32 adder operand loader.
package add_int32_pkg;
  localparam int WORD_W   = 32;
  localparam int ERRCNT_W = 8;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_FULL = 2'd2
  } loader_state_t;
endpackage

// File: rtl/add_int32_operand_loader_word_assembler.sv
// Beat counter plus indexed write register that builds one 32-bit operand
// from little-endian beats. The word output includes the beat being written.
module word_assembler
  import add_int32_pkg::*;
#(
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              we,
  input  logic [BEAT_W-1:0] data,
  output logic              done,
  output logic [WORD_W-1:0] word
);
  localparam int NBEATS = WORD_W / BEAT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [IDX_W-1:0]  idx_r;
  logic [WORD_W-1:0] word_r;
  logic [WORD_W-1:0] word_s;
  logic              at_last_s;

  assign at_last_s = (idx_r == IDX_W'(NBEATS - 1));
  assign done      = we && at_last_s;
  assign word      = word_s;

  // Merge the incoming beat into its lane so a completing word is usable this cycle.
  always_comb begin
    word_s = word_r;
    if (we) begin
      for (int i = 0; i < NBEATS; i++) begin
        if (idx_r == IDX_W'(i)) begin
          word_s[i*BEAT_W +: BEAT_W] = data;
        end else begin
          word_s[i*BEAT_W +: BEAT_W] = word_r[i*BEAT_W +: BEAT_W];
        end
      end
    end else begin
      word_s = word_r;
    end
  end

  // Counter and storage; clear wins over a write so a discarded beat never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= {IDX_W{1'b0}};
      word_r <= {WORD_W{1'b0}};
    end else if (clear) begin
      idx_r  <= {IDX_W{1'b0}};
      word_r <= {WORD_W{1'b0}};
    end else if (we) begin
      word_r <= word_s;
      idx_r  <= at_last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      idx_r  <= idx_r;
      word_r <= word_r;
    end
  end
endmodule

// File: rtl/add_int32_operand_loader.sv
// Collects operand a then b from a narrow beat stream and hands each pair to
// the adder through a one-entry valid/ready slot, with framing error tracking.
module add_int32_operand_loader
  import add_int32_pkg::*;
#(
  parameter int BEAT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BEAT_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_a,
  output logic [WORD_W-1:0]   out_b,
  output logic                err_framing,
  output logic [ERRCNT_W-1:0] err_count
);
  loader_state_t       state_r;
  loader_state_t       state_nx_s;
  logic                acc_s;
  logic                we_a_s;
  logic                we_b_s;
  logic                done_a_s;
  logic                done_b_s;
  logic                err_s;
  logic                slot_free_s;
  logic                load_s;
  logic [WORD_W-1:0]   word_a_s;
  logic [WORD_W-1:0]   word_b_s;
  logic                out_valid_r;
  logic [WORD_W-1:0]   out_a_r;
  logic [WORD_W-1:0]   out_b_r;
  logic                err_framing_r;
  logic [ERRCNT_W-1:0] err_count_r;

  assign in_ready    = (state_r != S_FULL);
  assign acc_s       = in_valid && in_ready;
  assign we_a_s      = acc_s && (state_r == S_A);
  assign we_b_s      = acc_s && (state_r == S_B);
  // in_last must coincide exactly with the final b beat; anything else is a framing error.
  assign err_s       = acc_s && (in_last != done_b_s);
  assign slot_free_s = !out_valid_r || out_ready;
  assign load_s      = slot_free_s && ((done_b_s && !err_s) || (state_r == S_FULL));

  word_assembler #(.BEAT_W(BEAT_W)) u_asm_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (err_s),
    .we    (we_a_s),
    .data  (in_data),
    .done  (done_a_s),
    .word  (word_a_s)
  );

  word_assembler #(.BEAT_W(BEAT_W)) u_asm_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (err_s),
    .we    (we_b_s),
    .data  (in_data),
    .done  (done_b_s),
    .word  (word_b_s)
  );

  // Assembly FSM next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_A: begin
        if (err_s)         state_nx_s = S_A;
        else if (done_a_s) state_nx_s = S_B;
        else               state_nx_s = S_A;
      end
      S_B: begin
        if (err_s)         state_nx_s = S_A;
        else if (done_b_s) state_nx_s = slot_free_s ? S_A : S_FULL;
        else               state_nx_s = S_B;
      end
      S_FULL: begin
        if (slot_free_s)   state_nx_s = S_A;
        else               state_nx_s = S_FULL;
      end
      default:             state_nx_s = S_A;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_A;
    else        state_r <= state_nx_s;
  end

  // Output slot: a load in the same cycle as a consume keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_a_r     <= {WORD_W{1'b0}};
      out_b_r     <= {WORD_W{1'b0}};
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_a_r     <= word_a_s;
      out_b_r     <= word_b_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Registered error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_framing_r <= 1'b0;
      err_count_r   <= {ERRCNT_W{1'b0}};
    end else begin
      err_framing_r <= err_s;
      if (err_s && (err_count_r != {ERRCNT_W{1'b1}})) err_count_r <= err_count_r + ERRCNT_W'(1);
      else                                            err_count_r <= err_count_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_a       = out_a_r;
  assign out_b       = out_b_r;
  assign err_framing = err_framing_r;
  assign err_count   = err_count_r;
endmodule

// File: tb/tb_add_int32_operand_loader.sv
// Directed bench: an 8-bit-beat loader for pairing, backpressure, framing and
// reset, and a 32-bit-beat loader for streaming and counter saturation.
module tb_add_int32_operand_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid8 = 1'b0, in_last8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  in_data8 = 8'h00;
  logic        in_ready8, out_valid8, err_framing8;
  logic [31:0] out_a8, out_b8;
  logic [7:0]  err_count8;

  logic        in_valid32 = 1'b0, in_last32 = 1'b0, out_ready32 = 1'b1;
  logic [31:0] in_data32 = 32'h0;
  logic        in_ready32, out_valid32, err_framing32;
  logic [31:0] out_a32, out_b32;
  logic [7:0]  err_count32;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] ref_q[$];
  logic [63:0] exp_pair;

  always #5 clk = ~clk;

  add_int32_operand_loader #(.BEAT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_last(in_last8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_a(out_a8), .out_b(out_b8),
    .err_framing(err_framing8), .err_count(err_count8)
  );

  add_int32_operand_loader #(.BEAT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_last(in_last32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_a(out_a32), .out_b(out_b32),
    .err_framing(err_framing32), .err_count(err_count32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input logic [7:0] d, input logic l);
    in_valid8 = 1'b1; in_data8 = d; in_last8 = l;
    step();
    in_valid8 = 1'b0; in_last8 = 1'b0;
  endtask

  task automatic word8(input logic [31:0] w, input logic last_final);
    for (int i = 0; i < 4; i++) beat8(w[i*8 +: 8], last_final && (i == 3));
  endtask

  task automatic pair8(input logic [31:0] a, input logic [31:0] b);
    word8(a, 1'b0);
    word8(b, 1'b1);
  endtask

  task automatic beat32(input logic [31:0] d, input logic l);
    in_valid32 = 1'b1; in_data32 = d; in_last32 = l;
    step();
    in_valid32 = 1'b0; in_last32 = 1'b0;
  endtask

  initial begin
    step(); step();
    // reset state
    chk("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("rst_out_ab", {out_a8, out_b8}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready8}, 64'd1);
    chk("rst_err", {55'd0, err_framing8, err_count8}, 64'd0);
    rst_n = 1'b1;
    step();

    // basic pair
    word8(32'h12345678, 1'b0);
    chk("basic_no_early_valid", {63'd0, out_valid8}, 64'd0);
    beat8(8'h01, 1'b0); beat8(8'h00, 1'b0); beat8(8'h00, 1'b0); beat8(8'h00, 1'b1);
    chk("basic_valid", {63'd0, out_valid8}, 64'd1);
    chk("basic_ab", {out_a8, out_b8}, {32'h12345678, 32'h00000001});
    step();
    chk("basic_consumed", {63'd0, out_valid8}, 64'd0);

    // backpressure
    out_ready8 = 1'b0;
    pair8(32'd1, 32'd2);
    chk("bp_p1", {out_a8, out_b8}, {32'd1, 32'd2});
    chk("bp_in_ready_p1", {63'd0, in_ready8}, 64'd1);
    pair8(32'd3, 32'd4);
    chk("bp_in_ready_drop", {63'd0, in_ready8}, 64'd0);
    chk("bp_hold", {31'd0, out_valid8, out_a8}, {31'd0, 1'b1, 32'd1});
    step();
    chk("bp_hold2", {out_a8, out_b8}, {32'd1, 32'd2});
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk("bp_swap_valid", {63'd0, out_valid8}, 64'd1);
    chk("bp_swap_ab", {out_a8, out_b8}, {32'd3, 32'd4});
    chk("bp_in_ready_back", {63'd0, in_ready8}, 64'd1);
    out_ready8 = 1'b1;
    step();
    chk("bp_drained", {63'd0, out_valid8}, 64'd0);

    // framing: early in_last
    beat8(8'hAA, 1'b0); beat8(8'hBB, 1'b0); beat8(8'hCC, 1'b1);
    chk("fr1_pulse", {63'd0, err_framing8}, 64'd1);
    chk("fr1_count", {56'd0, err_count8}, 64'd1);
    chk("fr1_no_out", {63'd0, out_valid8}, 64'd0);
    pair8(32'd5, 32'd6);
    chk("fr1_pulse_gone", {63'd0, err_framing8}, 64'd0);
    chk("fr1_recover", {31'd0, out_valid8, out_a8, out_b8}, {31'd0, 1'b1, 32'd5, 32'd6});
    step();

    // framing: missing in_last
    word8(32'd9, 1'b0);
    word8(32'd10, 1'b0);
    chk("fr2_pulse", {63'd0, err_framing8}, 64'd1);
    chk("fr2_count", {56'd0, err_count8}, 64'd2);
    chk("fr2_no_out", {63'd0, out_valid8}, 64'd0);
    pair8(32'hA5A5_0F0F, 32'hDEAD_BEEF);
    chk("fr2_recover", {out_a8, out_b8}, {32'hA5A5_0F0F, 32'hDEAD_BEEF});
    step();

    // reset mid-operation with a pending output
    out_ready8 = 1'b0;
    pair8(32'h11, 32'h22);
    word8(32'hFFFF_FFFF, 1'b0);
    beat8(8'h77, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {30'd0, out_valid8, err_framing8, out_a8}, 64'd0);
    chk("mid_rst_b_cnt", {24'd0, err_count8, out_b8}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready8}, 64'd1);
    step();
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    step();
    chk("post_rst_quiet", {63'd0, out_valid8}, 64'd0);
    pair8(32'd7, 32'd8);
    chk("post_rst_pair", {31'd0, out_valid8, out_a8, out_b8}, {31'd0, 1'b1, 32'd7, 32'd8});
    step();
    chk("post_rst_single", {63'd0, out_valid8}, 64'd0);

    // streaming with 32-bit beats
    for (int p = 0; p < 6; p++) begin
      logic [31:0] a, b;
      a = 32'h1000_0000 + 32'(p * 17);
      b = 32'hF000_0001 - 32'(p * 3);
      ref_q.push_back({a, b});
      chk("st_in_ready_a", {63'd0, in_ready32}, 64'd1);
      beat32(a, 1'b0);
      chk("st_gap", {63'd0, out_valid32}, 64'd0);
      chk("st_in_ready_b", {63'd0, in_ready32}, 64'd1);
      beat32(b, 1'b1);
      exp_pair = ref_q.pop_front();
      chk("st_valid", {63'd0, out_valid32}, 64'd1);
      chk("st_pair", {out_a32, out_b32}, exp_pair);
    end
    step();
    chk("st_end", {63'd0, out_valid32}, 64'd0);

    // saturation
    in_valid32 = 1'b1; in_last32 = 1'b1;
    for (int k = 0; k < 254; k++) step();
    chk("sat_254", {56'd0, err_count32}, 64'd254);
    step();
    chk("sat_255", {56'd0, err_count32}, 64'd255);
    for (int k = 0; k < 45; k++) step();
    in_valid32 = 1'b0; in_last32 = 1'b0;
    chk("sat_300", {56'd0, err_count32}, 64'd255);
    chk("sat_pulse", {63'd0, err_framing32}, 64'd1);
    step();
    chk("sat_pulse_end", {62'd0, err_framing32, out_valid32}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_int32_operand_loader.md
# add_int32_operand_loader

Upstream feeder for the 32-bit integer adder. Collects operand `a` and then operand `b` as a little-endian stream of narrow beats read from PIM memory rows, and assembles them into full 32-bit words. It presents each completed pair to the adder stage through a one-entry, valid/ready output buffer. A pair can be assembled while the previous pair waits for the adder, so the block tolerates adder-side backpressure without stalling the memory stream early.

## Interface
- `BEAT_W`, default 8, is the stream beat width. Legal values are 8, 16 and 32. `NBEATS = 32/BEAT_W` beats make one operand.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: the upstream beat is valid.
- `in_ready` output, 1 bit: the block accepts the beat this cycle.
- `in_data` input, `BEAT_W` bits: beat payload, least-significant beat first.
- `in_last` input, 1 bit: marks the final beat of `b`, which is beat `2*NBEATS-1` of the pair.
- `out_valid` output, 1 bit: `out_a` and `out_b` hold a complete pair.
- `out_ready` input, 1 bit: the adder consumes the pair this cycle.
- `out_a` output, 32 bits: operand a.
- `out_b` output, 32 bits: operand b.
- `err_framing` output, 1 bit: one-cycle pulse on a framing violation.
- `err_count` output, 8 bits: count of framing errors, saturating at 255.

## Operation
- Assembly FSM states:
  - S_A: collect `a`.
  - S_B: collect `b`.
  - S_FULL: a completed pair is waiting for the output slot.
- Beat counter `beat_idx` runs 0..`NBEATS-1`.
- An accepted beat (`in_valid && in_ready`) is written into bits `[beat_idx*BEAT_W +: BEAT_W]` of the operand being assembled.
- S_A to S_B happens on acceptance of beat `NBEATS-1`. `beat_idx` then wraps to 0.
- On acceptance of the final `b` beat, with `in_last` = 1:
  - If the output slot is free (`!out_valid || out_ready`), the pair loads into `out_a`/`out_b` and the FSM returns to S_A.
  - Otherwise the FSM moves to S_FULL.
- In S_FULL, the pair moves to the output slot on the first cycle where `!out_valid || out_ready`. The FSM then returns to S_A.
- `in_ready` = (state != S_FULL). It is combinational from state only and never depends on `in_valid`.
- Output slot rules:
  - `out_valid` sets when a pair loads.
  - `out_valid` clears on `out_valid && out_ready` unless a new pair loads in the same cycle; in that case it stays 1 and the data is replaced.
  - `out_a`/`out_b` are stable while `out_valid && !out_ready`.
- Framing errors have two cases:
  - `in_last` = 1 on any accepted beat other than the final `b` beat.
  - `in_last` = 0 on the final `b` beat.
- On a framing error:
  - `err_framing` pulses for one cycle and `err_count` increments (saturating).
  - The partial pair is discarded, including the offending beat. The FSM returns to S_A with `beat_idx` = 0.
  - The output slot is unaffected.
- No arithmetic is performed. Widths are exact, with no sign handling; operands are opaque 32-bit patterns.

## Timing
- Reset values:
  - Outputs: `out_valid` = 0, `out_a` = `out_b` = 0, `err_framing` = 0, `err_count` = 0.
  - `in_ready` = 1 (state S_A).
  - Internal: `beat_idx` = 0.
- Reset asserted mid-pair or with a pending output drops everything immediately; nothing is emitted after release.
- Latency: the final `b` beat accepted at cycle t gives `out_valid` = 1 at t+1 when the slot is free.
- Throughput: one pair per `2*NBEATS` cycles with `out_ready` held at 1. There are no bubbles on `in_ready`.
- Backpressure: with `out_ready` = 0, the next full pair is still accepted. `in_ready` drops in the cycle after that pair's final beat and rises the cycle after the slot frees.
- Simultaneous consume and load:
  - In S_FULL with `out_ready` = 1, the output takes the new pair in the same edge, so `out_valid` stays 1.
  - `in_ready` returns to 1 in the next cycle.
- `err_framing` is registered and asserts in the cycle after the offending beat.

## Structure
- Shared package `add_int32_pkg`: `WORD_W` = 32, the FSM state enum `loader_state_t` {S_A, S_B, S_FULL}, and the `ERRCNT_W` = 8 constant.
- One sub-module, `word_assembler`: beat counter plus a 32-bit indexed write register, instantiated twice (for `a` and `b`), with `done` and `clear` controls.
- The FSM, output slot and error counter live in the top module.

## Test plan
- Basic pair, `BEAT_W`=8: send beats 78,56,34,12 then 01,00,00,00 (`in_last` on the 8th), with `out_ready` = 1. Required: `out_a` = 0x12345678 and `out_b` = 0x00000001, with `out_valid` one cycle after the last beat.
- Backpressure: `out_ready` = 0; send two pairs, (1,2) then (3,4). Required:
  - `out_valid` stays 1 with (1,2).
  - `in_ready` drops after pair 2's last beat.
  - Raising `out_ready` for one cycle gives (3,4) next cycle with `out_valid` still 1.
- Framing errors: `in_last` on beat 3 of `a`, then a clean pair (5,6). Required: one `err_framing` pulse, `err_count` = 1, and an output of exactly (5,6). Repeat with `in_last` missing on the final beat: `err_count` = 2 and no output.
- Reset mid-operation: assert `rst_n` = 0 after 5 beats, then release and send (7,8). Required: all outputs reset and the single output (7,8).
- Streaming, `BEAT_W`=32: continuous pairs with `out_ready` = 1. Required: one `out_valid` every 2 cycles, `in_ready` constantly 1, and operands matching a reference queue.
- Saturation: inject 300 framing errors. Required: `err_count` = 255.
